ofifo_4bit: RTL and testbench
=============================

Name: ofifo_4bit

Overview:
- Output FIFO directly downstream of the SFP stage.
- Accepts per-column quantized activations (act_out/act_valid from SFP) that may arrive skewed in time across columns.
- Re-aligns them and presents complete rows of col activations to the output/activation-SRAM writer.
- Read side uses a valid/read handshake.

Parameters:
- col, 8, number of columns (one independent lane per column)
- act_bw, 4, bits per activation
- depth, 8, entries per column lane; power of 2, minimum 2

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  col*act_bw  per-column activation data; column i at bits [(i+1)*act_bw-1 : i*act_bw]
- wr  input  col  per-column write strobe (driven from SFP act_valid)
- rd  input  1  row read request from the consumer
- out  output  col*act_bw  head row, same column packing as in
- o_valid  output  1  every column lane is non-empty; a full row is available
- o_full  output  1  at least one column lane is full
- o_ready  output  1  no column lane is full (equals ~o_full)
- o_overflow  output  1  sticky flag; a write was dropped

Behaviour:
- Reset (synchronous, active-high):
  - All read/write pointers and counters are cleared; o_overflow is cleared.
  - On the cycle after reset: o_valid=0, o_full=0, o_ready=1, out=0.
  - Reset asserted mid-operation discards all stored entries; no partial row survives.
  - Any wr or rd during a reset cycle is ignored.
- Storage:
  - col independent circular buffers of depth entries × act_bw bits.
  - Each lane has a write pointer, a read pointer and an occupancy count of width clog2(depth)+1.
  - Pointers wrap from depth-1 to 0.
- Write:
  - Column i writes in[i] at its write pointer when wr[i]=1 and lane i is not full.
  - Fullness is evaluated from the pre-edge count.
  - Writes to different columns are fully independent and may occur in any cycle and in any order.
  - A write to a full lane is dropped, even if rd pops that lane in the same cycle. That lane's pointer and count are unchanged, and o_overflow is set to 1.
  - o_overflow stays at 1 until reset.
- Read:
  - The row is popped on a rising edge when rd=1 and o_valid=1.
  - A pop advances every lane's read pointer by one and decrements every count.
  - rd while o_valid=0 is ignored: no state change, no error.
- Output:
  - First-word-fall-through.
  - When o_valid=1, out shows the head entry of each lane, driven combinationally from storage and pointers.
  - When o_valid=0, out is forced to all zeros.
- Flags (combinational from counts):
  - o_valid = AND over lanes of (count != 0).
  - o_full = OR over lanes of (count == depth).
  - o_ready = ~o_full.
- Latency:
  - Data written at edge N can appear on out and raise o_valid in the cycle after edge N, if all other lanes are already non-empty.
  - Pop at edge N exposes the next row on out in the cycle after edge N.
- Simultaneous write and pop on a non-full lane: both take effect, and the count is unchanged.
- Throughput:
  - A steady stream of one full row written and one row popped per cycle is sustainable indefinitely without overflow.
  - Order is strict FIFO per lane. Rows are assembled by per-lane position, so the k-th write of every column forms row k.

Test Plan:
- Reset, then write one row in a single cycle with column i = i (0x76543210 for col=8, act_bw=4) -> next cycle o_valid=1, out=0x76543210; assert rd -> o_valid=0 and out=0 on the following cycle.
- Skewed write: columns 0–3 write 0xA at cycle 0, columns 4–7 write 0x5 at cycle 3 -> o_valid stays 0 through cycle 3 and rises in cycle 4 with out=0x5555AAAA.
- Fill depth=8 rows with values 1..8 and no reads -> o_full=1 and o_ready=0 after the 8th write; 9th write of 0xF with rd=1 in the same cycle -> write dropped, o_overflow=1. Subsequent reads return rows 2..8 with no 0xF row.
- Streaming: 20 consecutive cycles of write row r and rd=1 after a 1-row prefill -> read rows come out in exact order, o_full never asserts, o_overflow stays 0, and pointer wrap-around is exercised.
- rd with o_valid=0 on an empty FIFO and on a partially filled lane set -> no count change; a later full row still reads out correctly.
- Reset mid-stream with 5 rows stored and wr/rd active -> cycle after reset: o_valid=0, o_full=0, o_overflow=0, out=0; the next written row reads back as the first row.

Source files
------------

// File: rtl/ofifo_4bit.sv
// Output FIFO after the SFP stage: per-column lanes absorb skewed activation writes
// and present complete, column-aligned rows to the writer with first-word-fall-through.
module ofifo_4bit #(
    parameter int col    = 8,
    parameter int act_bw = 4,
    parameter int depth  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [col*act_bw-1:0] in,
    input  logic [col-1:0]        wr,
    input  logic                  rd,
    output logic [col*act_bw-1:0] out,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_ready,
    output logic                  o_overflow
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = PW + 1;

    logic [act_bw-1:0] r_mem  [col][depth];
    logic [PW-1:0]     r_wptr [col];
    logic [PW-1:0]     r_rptr [col];
    logic [CW-1:0]     r_cnt  [col];
    logic              r_overflow;

    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic [col-1:0]    w_wen;
    logic [col-1:0]    w_drop;

    // Flags and the head row come straight from counts and read pointers
    always_comb begin
        w_valid = 1'b1;
        w_full  = 1'b0;
        w_wen   = '0;
        w_drop  = '0;
        out     = '0;
        for (int i = 0; i < col; i++) begin
            if (r_cnt[i] == '0)
                w_valid = 1'b0;
            if (r_cnt[i] == CW'(depth))
                w_full = 1'b1;
            // A full lane drops its write even if the same edge pops it
            w_wen[i]  = wr[i] && (r_cnt[i] != CW'(depth));
            w_drop[i] = wr[i] && (r_cnt[i] == CW'(depth));
        end
        w_pop = rd && w_valid;
        if (w_valid) begin
            for (int i = 0; i < col; i++)
                out[i*act_bw +: act_bw] = r_mem[i][r_rptr[i]];
        end
    end

    assign o_valid    = w_valid;
    assign o_full     = w_full;
    assign o_ready    = ~w_full;
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (w_wen[i])
                    r_wptr[i] <= r_wptr[i] + PW'(1);
                if (w_pop)
                    r_rptr[i] <= r_rptr[i] + PW'(1);
                case ({w_wen[i], w_pop})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (|w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; pointers and counts alone define what is live
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (!reset && w_wen[i])
                r_mem[i][r_wptr[i]] <= in[i*act_bw +: act_bw];
        end
    end

endmodule

// File: tb/tb_ofifo_4bit.sv
// Randomized/directed bench for ofifo_4bit: per-lane queue model feeds a row scoreboard
// consumed by an independent monitor whenever the DUT pops a row.
module tb_ofifo_4bit;

    localparam int COL = 8;
    localparam int ABW = 4;
    localparam int DEP = 8;

    logic              clk;
    logic              reset;
    logic [COL*ABW-1:0] in;
    logic [COL-1:0]    wr;
    logic              rd;
    logic [COL*ABW-1:0] out;
    logic              o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_overflow;

    int errors = 0;
    int checks = 0;

    logic [ABW-1:0]     lq [COL][$];
    logic               m_ovf;
    logic [COL*ABW-1:0] sb [$];

    ofifo_4bit #(.col(COL), .act_bw(ABW), .depth(DEP)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [COL*ABW-1:0] heads();
        logic [COL*ABW-1:0] r;
        r = '0;
        for (int i = 0; i < COL; i++)
            r[i*ABW +: ABW] = lq[i][0];
        return r;
    endfunction

    function automatic logic m_valid();
        for (int i = 0; i < COL; i++)
            if (lq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < COL; i++)
            if (lq[i].size() == DEP) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every row the DUT pops must match the oldest expected row
    always @(negedge clk) begin
        if (!reset && rd && o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got row %0h expected no pop", out);
            end else begin
                chk("pop_row", 64'(out), 64'(sb.pop_front()));
            end
        end
    end

    task automatic check_state();
        logic v;
        v = m_valid();
        chk("o_valid", 64'(o_valid), 64'(v));
        chk("o_full", 64'(o_full), 64'(m_full()));
        chk("o_ready", 64'(o_ready), 64'(!m_full()));
        chk("o_overflow", 64'(o_overflow), 64'(m_ovf));
        chk("out", 64'(out), v ? 64'(heads()) : 64'd0);
    endtask

    // One clock: drive inputs, advance the model to the post-edge state, then compare
    task automatic cycle(input logic [COL-1:0] m, input logic [COL*ABW-1:0] d, input logic r);
        logic           vpre;
        logic [COL-1:0] fpre;
        wr = m; in = d; rd = r;
        vpre = m_valid();
        for (int i = 0; i < COL; i++)
            fpre[i] = (lq[i].size() == DEP);
        if (r && vpre) begin
            sb.push_back(heads());
            for (int i = 0; i < COL; i++)
                void'(lq[i].pop_front());
        end
        for (int i = 0; i < COL; i++) begin
            if (m[i]) begin
                if (fpre[i]) m_ovf = 1'b1;
                else lq[i].push_back(d[i*ABW +: ABW]);
            end
        end
        @(posedge clk);
        #1;
        wr = '0; rd = 1'b0;
        check_state();
    endtask

    task automatic do_reset(input logic noisy);
        reset = 1'b1;
        wr = noisy ? COL'($urandom) : '0;
        in = COL*ABW'($urandom);
        rd = noisy;
        for (int i = 0; i < COL; i++)
            lq[i].delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0; wr = '0; rd = 1'b0;
        check_state();
    endtask

    function automatic logic [COL*ABW-1:0] rep(input logic [ABW-1:0] v);
        return {COL{v}};
    endfunction

    initial begin
        reset = 1'b1; wr = '0; in = '0; rd = 1'b0; m_ovf = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Single aligned row, then pop it
        cycle(8'hFF, 32'h76543210, 1'b0);
        chk("row0_out", 64'(out), 64'h76543210);
        cycle(8'h00, 32'h0, 1'b1);
        chk("row0_popped_out", 64'(out), 64'h0);

        // Skewed columns
        cycle(8'h0F, 32'hAAAAAAAA, 1'b0);
        cycle(8'h00, 32'h0, 1'b0);
        cycle(8'h00, 32'h0, 1'b0);
        cycle(8'hF0, 32'h55555555, 1'b0);
        chk("skew_out", 64'(out), 64'h5555AAAA);
        cycle(8'h00, 32'h0, 1'b1);

        // Fill to depth, then a dropped write alongside a pop
        for (int v = 1; v <= DEP; v++)
            cycle(8'hFF, rep(ABW'(v)), 1'b0);
        chk("full_flag", 64'(o_full), 64'd1);
        cycle(8'hFF, 32'hFFFFFFFF, 1'b1);
        chk("ovf_set", 64'(o_overflow), 64'd1);
        for (int k = 0; k < DEP - 1; k++)
            cycle(8'h00, 32'h0, 1'b1);
        do_reset(1'b0);

        // Streaming with wrap-around
        cycle(8'hFF, rep(4'h0), 1'b0);
        for (int r = 1; r <= 20; r++)
            cycle(8'hFF, rep(ABW'(r)) ^ 32'h01234567, 1'b1);
        cycle(8'h00, 32'h0, 1'b1);

        // rd while empty / partially filled
        cycle(8'h00, 32'h0, 1'b1);
        cycle(8'h0F, 32'h00003C5A, 1'b1);
        cycle(8'h00, 32'h0, 1'b1);
        cycle(8'hF0, 32'h9E7B0000, 1'b0);
        cycle(8'h00, 32'h0, 1'b1);

        // Mid-stream reset
        for (int r = 0; r < 5; r++)
            cycle(8'hFF, 32'($urandom), 1'b0);
        do_reset(1'b1);
        cycle(8'hFF, 32'hC0FFEE42, 1'b0);
        chk("post_reset_head", 64'(out), 64'hC0FFEE42);
        cycle(8'h00, 32'h0, 1'b1);

        // Random traffic
        for (int k = 0; k < 300; k++)
            cycle(($urandom_range(0, 3) == 0) ? COL'($urandom) : 8'hFF,
                  32'($urandom), 1'($urandom_range(0, 1)));
        do_reset(1'b1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
